// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath widths, ALU op codes and forwarding-select encoding
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int CNTW = 16;
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_t;
    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_t;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: picks the freshest value of one EX source register
// Ports: rs (registered source index), rf_data (registered RF value),
//        exmem_*/memwb_* (younger/older writers in flight), data (selected operand)
module fwd_unit #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int REGW = riscv_pkg::REGW
) (
    input  logic [REGW-1:0] rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            exmem_regwrite,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_regwrite,
    input  logic [REGW-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_wdata,
    output logic [XLEN-1:0] data
);
    import riscv_pkg::*;
    fwd_sel_t sel;
    // EX/MEM is younger than MEM/WB, so it wins when both target rs; x0 is never forwarded
    always_comb begin
        sel  = (exmem_regwrite && exmem_rd != '0 && exmem_rd == rs) ? FWD_EXMEM :
               (memwb_regwrite && memwb_rd != '0 && memwb_rd == rs) ? FWD_MEMWB : FWD_RF;
        data = (sel == FWD_EXMEM) ? exmem_result :
               (sel == FWD_MEMWB) ? memwb_wdata : rf_data;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX operand forwarding and load-use bubbles
// Ports: stall/flush (hold / kill), id_* (decoded fields from ID),
//        exmem_*/memwb_* (forwarding sources), lu_stall (IF/ID hold request),
//        ex_* (registered EX slot, forwarded ALU operands), bubble_cnt (saturating bubble count)
module id_ex_stage #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int REGW = riscv_pkg::REGW,
    parameter int CNTW = riscv_pkg::CNTW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [2:0]      id_aluop,
    input  logic            id_alusrc,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_memtoreg,
    input  logic            exmem_regwrite,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_regwrite,
    input  logic [REGW-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_wdata,
    output logic            lu_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [2:0]      ex_aluoperation,
    output logic [XLEN-1:0] ex_store_data,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_memtoreg,
    output logic [CNTW-1:0] bubble_cnt
);
    import riscv_pkg::*;
    logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q, fwd_b;
    logic [REGW-1:0] rs1_q, rs2_q;
    logic            alusrc_q, regwrite_q, memread_q, memwrite_q, memtoreg_q;
    logic            bubble;
    assign lu_stall = ex_valid & memread_q & (ex_rd != '0) & id_valid &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    // stall outranks a load-use bubble but not a flush
    assign bubble = flush | (~stall & lu_stall);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid        <= 1'b0;
            ex_pc           <= '0;
            ex_rd           <= '0;
            ex_aluoperation <= ALU_ADD;
            rs1_data_q      <= '0;
            rs2_data_q      <= '0;
            imm_q           <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            alusrc_q        <= 1'b0;
            regwrite_q      <= 1'b0;
            memread_q       <= 1'b0;
            memwrite_q      <= 1'b0;
            memtoreg_q      <= 1'b0;
            bubble_cnt      <= '0;
        end else if (bubble) begin
            ex_valid   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            bubble_cnt <= bubble_cnt + {{(CNTW-1){1'b0}}, ~&bubble_cnt};
        end else if (!stall) begin
            ex_valid        <= id_valid;
            ex_pc           <= id_pc;
            ex_rd           <= id_rd;
            ex_aluoperation <= id_aluop;
            rs1_data_q      <= id_rs1_data;
            rs2_data_q      <= id_rs2_data;
            imm_q           <= id_imm;
            rs1_q           <= id_rs1;
            rs2_q           <= id_rs2;
            alusrc_q        <= id_alusrc;
            regwrite_q      <= id_regwrite;
            memread_q       <= id_memread;
            memwrite_q      <= id_memwrite;
            memtoreg_q      <= id_memtoreg;
        end
    end
    fwd_unit #(.XLEN(XLEN), .REGW(REGW)) u_fwd_a (
        .rs(rs1_q), .rf_data(rs1_data_q),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .data(ex_a)
    );
    fwd_unit #(.XLEN(XLEN), .REGW(REGW)) u_fwd_b (
        .rs(rs2_q), .rf_data(rs2_data_q),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .data(fwd_b)
    );
    assign ex_store_data = fwd_b;
    assign ex_b          = alusrc_q ? imm_q : fwd_b;
    // bubbles must never cause writes downstream
    assign ex_regwrite   = ex_valid & regwrite_q;
    assign ex_memread    = ex_valid & memread_q;
    assign ex_memwrite   = ex_valid & memwrite_q;
    assign ex_memtoreg   = ex_valid & memtoreg_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage against a slot-level reference model
module tb_id_ex_stage;
    logic        clk = 0, rst_n = 0, stall = 0, flush = 0, id_valid = 0;
    logic [31:0] id_pc = 0, id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
    logic [4:0]  id_rs1 = 0, id_rs2 = 0, id_rd = 0;
    logic [2:0]  id_aluop = 0;
    logic        id_alusrc = 0, id_regwrite = 0, id_memread = 0, id_memwrite = 0, id_memtoreg = 0;
    logic        exmem_regwrite = 0, memwb_regwrite = 0;
    logic [4:0]  exmem_rd = 0, memwb_rd = 0;
    logic [31:0] exmem_result = 0, memwb_wdata = 0;
    logic        lu_stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic [31:0] ex_pc, ex_a, ex_b, ex_store_data;
    logic [2:0]  ex_aluoperation;
    logic [4:0]  ex_rd;
    logic [15:0] bubble_cnt;
    int tests = 0, fails = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_aluop(id_aluop),
        .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .lu_stall(lu_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
        .ex_aluoperation(ex_aluoperation), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // reference model: the instruction currently sitting in EX and the bubble tally
    logic        m_valid, m_alusrc, m_rw, m_mr, m_mw, m_mt;
    logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_aluop;
    int          m_cnt;

    task automatic model_reset();
        m_valid = 0; m_alusrc = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mt = 0;
        m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_aluop = 0; m_cnt = 0;
    endtask

    function automatic bit exp_lu();
        return m_valid && m_mr && m_rd != 0 && id_valid && (m_rd == id_rs1 || m_rd == id_rs2);
    endfunction

    function automatic logic [31:0] exp_fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (exmem_regwrite && exmem_rd == idx) return exmem_result;
        if (memwb_regwrite && memwb_rd == idx) return memwb_wdata;
        return rf;
    endfunction

    // advance the model by one clock using the inputs now applied, then let the DUT clock
    task automatic tick();
        if (flush || (!stall && exp_lu())) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mt = 0;
            if (m_cnt < 65535) m_cnt++;
        end else if (!stall) begin
            m_valid = id_valid; m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data;
            m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_aluop = id_aluop;
            m_alusrc = id_alusrc; m_rw = id_regwrite; m_mr = id_memread;
            m_mw = id_memwrite; m_mt = id_memtoreg;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_aluop = 3'b000; id_alusrc = 0; id_imm = 0;
        id_regwrite = 1; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        #12;
        tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_ex_valid: got %b expected 0", ex_valid); end
        tests++; if (bubble_cnt !== 16'h0) begin fails++; $display("FAIL reset_bubble_cnt: got %h expected 0000", bubble_cnt); end
        tests++; if (ex_aluoperation !== 3'b000) begin fails++; $display("FAIL reset_aluop: got %b expected 000", ex_aluoperation); end
        tests++; if ({ex_a, ex_b, ex_pc} !== 96'h0) begin fails++; $display("FAIL reset_data: got a=%h b=%h pc=%h expected 0", ex_a, ex_b, ex_pc); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic();
        set_id(5'd1, 5'd2, 5'd5, 32'd5, 32'd7);
        tick();
        tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b expected 1", ex_valid); end
        tests++; if (ex_a !== 32'd5) begin fails++; $display("FAIL basic_a: got %h expected 5", ex_a); end
        tests++; if (ex_b !== 32'd7) begin fails++; $display("FAIL basic_b: got %h expected 7", ex_b); end
        tests++; if (ex_aluoperation !== 3'b000) begin fails++; $display("FAIL basic_aluop: got %b expected 000", ex_aluoperation); end
        tests++; if (ex_regwrite !== 1'b1) begin fails++; $display("FAIL basic_regwrite: got %b expected 1", ex_regwrite); end
    endtask

    task automatic test_forward();
        set_id(5'd3, 5'd3, 5'd6, 32'h11, 32'h22);
        tick();
        exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'hAA;
        memwb_regwrite = 1; memwb_rd = 3; memwb_wdata = 32'hBB;
        #1;
        tests++; if (ex_a !== 32'hAA) begin fails++; $display("FAIL fwd_exmem_prio: got %h expected 000000aa", ex_a); end
        tests++; if (ex_store_data !== 32'hAA) begin fails++; $display("FAIL fwd_store: got %h expected 000000aa", ex_store_data); end
        exmem_regwrite = 0;
        #1;
        tests++; if (ex_a !== 32'hBB) begin fails++; $display("FAIL fwd_memwb: got %h expected 000000bb", ex_a); end
        memwb_regwrite = 0;
        #1;
        tests++; if (ex_a !== 32'h11) begin fails++; $display("FAIL fwd_rf: got %h expected 00000011", ex_a); end
        set_id(5'd1, 5'd2, 5'd7, 32'h1, 32'h2);
        id_alusrc = 1; id_imm = 32'h1234;
        tick();
        tests++; if (ex_b !== 32'h1234) begin fails++; $display("FAIL imm_b: got %h expected 00001234", ex_b); end
        tests++; if (ex_store_data !== 32'h2) begin fails++; $display("FAIL imm_store: got %h expected 00000002", ex_store_data); end
    endtask

    task automatic test_x0();
        set_id(5'd0, 5'd0, 5'd8, 32'h0, 32'h0);
        tick();
        exmem_regwrite = 1; exmem_rd = 0; exmem_result = 32'hDEAD;
        memwb_regwrite = 1; memwb_rd = 0; memwb_wdata = 32'hBEEF;
        #1;
        tests++; if (ex_a !== 32'h0) begin fails++; $display("FAIL x0_a: got %h expected 0", ex_a); end
        tests++; if (ex_store_data !== 32'h0) begin fails++; $display("FAIL x0_store: got %h expected 0", ex_store_data); end
        exmem_regwrite = 0; memwb_regwrite = 0;
    endtask

    task automatic test_load_use();
        int c;
        set_id(5'd1, 5'd2, 5'd4, 32'h0, 32'h0);
        id_memread = 1; id_memtoreg = 1;
        tick();
        set_id(5'd1, 5'd4, 5'd9, 32'h0, 32'h0);
        #1;
        tests++; if (lu_stall !== 1'b1) begin fails++; $display("FAIL lu_detect: got %b expected 1", lu_stall); end
        c = m_cnt;
        tick();
        tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble_valid: got %b expected 0", ex_valid); end
        tests++; if (ex_regwrite !== 1'b0) begin fails++; $display("FAIL lu_bubble_rw: got %b expected 0", ex_regwrite); end
        tests++; if (bubble_cnt !== 16'(c + 1)) begin fails++; $display("FAIL lu_count: got %0d expected %0d", bubble_cnt, c + 1); end
        tests++; if (lu_stall !== 1'b0) begin fails++; $display("FAIL lu_release: got %b expected 0", lu_stall); end
        tick();
        tests++; if (ex_rd !== 5'd9 || ex_valid !== 1'b1) begin fails++; $display("FAIL lu_resume: got rd=%0d v=%b expected rd=9 v=1", ex_rd, ex_valid); end
    endtask

    task automatic test_stall();
        set_id(5'd1, 5'd2, 5'd10, 32'h55, 32'h66);
        id_pc = 32'h100;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_pc = $urandom; id_rs1_data = $urandom; id_rd = 5'($urandom); id_valid = 1'($urandom);
            tick();
            tests++; if (ex_pc !== 32'h100 || ex_a !== 32'h55 || ex_rd !== 5'd10 || ex_valid !== 1'b1)
                begin fails++; $display("FAIL stall_hold%0d: got pc=%h a=%h rd=%0d v=%b expected pc=100 a=55 rd=10 v=1", i, ex_pc, ex_a, ex_rd, ex_valid); end
        end
        flush = 1;
        tick();
        tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL stall_flush: got %b expected 0", ex_valid); end
        tests++; if (bubble_cnt !== 16'(m_cnt)) begin fails++; $display("FAIL stall_flush_cnt: got %0d expected %0d", bubble_cnt, m_cnt); end
        flush = 0; stall = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            flush = ($urandom_range(15) == 0); stall = ($urandom_range(7) == 0);
            id_valid = 1'($urandom); id_pc = $urandom; id_imm = $urandom;
            id_rs1_data = $urandom; id_rs2_data = $urandom;
            id_rs1 = 5'($urandom_range(7)); id_rs2 = 5'($urandom_range(7)); id_rd = 5'($urandom_range(7));
            id_aluop = 3'($urandom); id_alusrc = 1'($urandom); id_regwrite = 1'($urandom);
            id_memread = 1'($urandom); id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom);
            exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(7)); exmem_result = $urandom;
            memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(7)); memwb_wdata = $urandom;
            #1;
            tests++; if (lu_stall !== exp_lu()) begin fails++; $display("FAIL rnd_lu[%0d]: got %b expected %b", i, lu_stall, exp_lu()); end
            tests++; if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} !==
                         {m_valid, m_valid & m_rw, m_valid & m_mr, m_valid & m_mw, m_valid & m_mt})
                begin fails++; $display("FAIL rnd_ctrl[%0d]: got %b%b%b%b%b expected %b%b%b%b%b", i, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, m_valid, m_valid & m_rw, m_valid & m_mr, m_valid & m_mw, m_valid & m_mt); end
            tests++; if (bubble_cnt !== 16'(m_cnt)) begin fails++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, bubble_cnt, m_cnt); end
            if (m_valid) begin
                tests++; if (ex_a !== exp_fwd(m_rs1, m_rs1d)) begin fails++; $display("FAIL rnd_a[%0d]: got %h expected %h", i, ex_a, exp_fwd(m_rs1, m_rs1d)); end
                tests++; if (ex_store_data !== exp_fwd(m_rs2, m_rs2d)) begin fails++; $display("FAIL rnd_store[%0d]: got %h expected %h", i, ex_store_data, exp_fwd(m_rs2, m_rs2d)); end
                tests++; if (ex_b !== (m_alusrc ? m_imm : exp_fwd(m_rs2, m_rs2d))) begin fails++; $display("FAIL rnd_b[%0d]: got %h expected %h", i, ex_b, m_alusrc ? m_imm : exp_fwd(m_rs2, m_rs2d)); end
                tests++; if ({ex_pc, ex_rd, ex_aluoperation} !== {m_pc, m_rd, m_aluop}) begin fails++; $display("FAIL rnd_fields[%0d]: got pc=%h rd=%0d op=%b expected pc=%h rd=%0d op=%b", i, ex_pc, ex_rd, ex_aluoperation, m_pc, m_rd, m_aluop); end
            end
            tick();
        end
        flush = 0; stall = 0; exmem_regwrite = 0; memwb_regwrite = 0;
    endtask

    task automatic test_saturate();
        flush = 1;
        for (int i = 0; i < 65538; i++) tick();
        tests++; if (bubble_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_cnt: got %h expected ffff", bubble_cnt); end
        tests++; if (bubble_cnt !== 16'(m_cnt)) begin fails++; $display("FAIL sat_model: got %h expected %h", bubble_cnt, 16'(m_cnt)); end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        tests++; if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, lu_stall} !== 6'b0)
            begin fails++; $display("FAIL async_rst_ctrl: got %b expected 000000", {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, lu_stall}); end
        tests++; if (bubble_cnt !== 16'h0) begin fails++; $display("FAIL async_rst_cnt: got %h expected 0000", bubble_cnt); end
        tests++; if ({ex_a, ex_b, ex_store_data, ex_pc} !== 128'h0 || ex_rd !== 5'd0 || ex_aluoperation !== 3'd0)
            begin fails++; $display("FAIL async_rst_data: got a=%h b=%h sd=%h pc=%h rd=%0d op=%b expected 0", ex_a, ex_b, ex_store_data, ex_pc, ex_rd, ex_aluoperation); end
        flush = 0;
        @(negedge clk);
        rst_n = 1;
        set_id(5'd1, 5'd2, 5'd3, 32'h77, 32'h88);
        tick();
        tests++; if (ex_valid !== 1'b1 || ex_a !== 32'h77 || bubble_cnt !== 16'h0)
            begin fails++; $display("FAIL post_rst: got v=%b a=%h cnt=%h expected v=1 a=77 cnt=0", ex_valid, ex_a, bubble_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_x0();
        test_load_use();
        test_stall();
        test_random();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
